dm_access_unit: RTL and testbench
=================================

DM_ACCESS_UNIT -- requirements
Module: dm_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles spent waiting for bus_ready before a bus error is raised.
REQ-002 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port mem_rd / mem_wr  input  1 each  SHALL be the M-stage load and store requests; both high SHALL be treated as store.
REQ-005 Port size  input  2  SHALL encode the access size: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-006 Port addr  input  32  SHALL be the byte address. Port wdata  input  32  SHALL be the store data, right-aligned.
REQ-007 Port extop_in  input  3  SHALL be the load-extension code carried with the access (000 none, 001 lb, 010 lbu, 011 lh, 100 lhu).
REQ-008 Port flush  input  1  SHALL cancel a request presented in IDLE.
REQ-009 Port stall  output  1  SHALL freeze the upstream pipeline.
REQ-010 Ports adel / ades  output  1 each  SHALL flag a misaligned load / store.
REQ-011 Ports bus_req, bus_we  output  1;  bus_addr  output  32;  bus_be  output  4;  bus_wdata  output  32;  bus_rdata  input  32;  bus_ready  input  1  SHALL form the memory handshake.
REQ-012 Ports DM  output  32;  BE  output  4;  extop_2  output  3;  valid_out  output  1;  bus_err  output  1  SHALL feed the downstream load extender.

Function
REQ-013 BE generation: word 1111; half 0011 when addr[1]=0, else 1100; byte 0001 shifted left by addr[1:0].
REQ-014 Store data: word passes unchanged; half replicates wdata[15:0] twice; byte replicates wdata[7:0] four times.
REQ-015 Misalignment: half with addr[0]=1, or word with addr[1:0]!=00, SHALL assert adel (load) or ades (store) combinationally for that cycle, start no bus access and leave stall low.
REQ-016 FSM states: IDLE, WAIT, RESP.
REQ-017 IDLE->WAIT: on an aligned request with flush=0. The block SHALL register bus_addr={addr[31:2],00}, bus_be, bus_wdata, bus_we and extop_in, and SHALL drive bus_req=1 from the next cycle.
REQ-018 stall SHALL be 1 in the IDLE cycle that accepts a request and throughout WAIT, and SHALL be 0 in RESP and otherwise.
REQ-019 WAIT->RESP: bus_ready sampled high. bus_req SHALL drop in the same edge. For a load, DM SHALL capture bus_rdata; BE and extop_2 SHALL present the registered values.
REQ-020 RESP SHALL last exactly one cycle with valid_out=1 and then return to IDLE. Minimum request-to-valid_out latency with zero-wait memory: 2 cycles.
REQ-021 Timeout: a wait counter SHALL clear on entry to WAIT and increment each WAIT cycle. When it reaches TIMEOUT without bus_ready, the block SHALL enter RESP with bus_err=1, valid_out=0 and DM=0.
REQ-022 For a store, DM SHALL hold its previous value, valid_out SHALL pulse and extop_2 SHALL be 000.
REQ-023 flush SHALL be ignored in WAIT; an access in flight always completes.
REQ-024 Outside RESP, extop_2 SHALL be 000 and BE SHALL be 1111, so the downstream stage passes data unchanged.

Reset
REQ-025 reset_n low SHALL immediately force: state IDLE, bus_req 0, bus_we 0, bus_addr 0, bus_be 0, bus_wdata 0, DM 0, BE 1111, extop_2 000, valid_out 0, bus_err 0, counter 0.
REQ-026 Reset during WAIT SHALL abandon the access; no valid_out follows.

Structure
REQ-027 Size codes, extop codes, FSM state encodings and the TIMEOUT default SHALL live in a shared package used by the decoder and the extender.
REQ-028 BE/store-data/alignment logic SHALL be a combinational sub-module named be_gen.

Verification
REQ-029 lb at addr 0x0000_0006, bus_rdata 0x8899_AABB, ready on first WAIT cycle -> bus_be 0100, valid_out at cycle 2, DM 0x8899_AABB, BE 0100, extop_2 001.
REQ-030 sh at addr 0x0000_0002, wdata 0x0000_1234 -> bus_we 1, bus_be 1100, bus_wdata 0x1234_1234, bus_addr 0x0000_0000.
REQ-031 lw at addr 0x0000_0005 -> adel 1 for that cycle, bus_req never asserted, stall 0.
REQ-032 With TIMEOUT=4 and bus_ready held 0 -> bus_err pulses once, stall drops, and the FSM returns to IDLE.
REQ-033 reset_n low in the second WAIT cycle -> bus_req 0 immediately, no valid_out; a following sw completes normally.
REQ-034 Back-to-back lw then sw, each with 3 wait cycles -> two valid_out pulses, and stall covers both accesses except their RESP cycles.

Source files
------------

// File: rtl/dm_access_unit_pkg.sv
// Shared encodings for the M-stage data memory access path:
// access sizes, load-extension codes, FSM states and the default timeout.
package dm_access_unit_pkg;

    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        SZ_WORD  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_BYTE  = 2'b10,
        SZ_WORD3 = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        EXT_NONE = 3'b000,
        EXT_LB   = 3'b001,
        EXT_LBU  = 3'b010,
        EXT_LH   = 3'b011,
        EXT_LHU  = 3'b100
    } extop_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/be_gen.sv
// Byte-enable, store-data replication and alignment check for one access.
module be_gen
    import dm_access_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] sdata,
    output logic        misaligned
);

    always_comb begin
        be         = 4'b1111;
        sdata      = wdata;
        misaligned = 1'b0;
        unique case (size)
            SZ_HALF: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                sdata      = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            SZ_BYTE: begin
                be    = 4'b0001 << addr_lo;
                sdata = {4{wdata[7:0]}};
            end
            SZ_WORD, SZ_WORD3: begin
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// M-stage data memory access unit: decodes a load/store, runs the bus
// handshake with timeout, and presents the response to the load extender.
module dm_access_unit
    import dm_access_unit_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  extop_in,
    input  logic        flush,
    output logic        stall,
    output logic        adel,
    output logic        ades,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic [31:0] DM,
    output logic [3:0]  BE,
    output logic [2:0]  extop_2,
    output logic        valid_out,
    output logic        bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    state_e        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          to_hit;
    logic          accept;
    logic          err_q;
    logic [2:0]    ext_q;
    logic [3:0]    be;
    logic [31:0]   sdata;
    logic          misaligned;

    be_gen u_be_gen (
        .size       (size),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .be         (be),
        .sdata      (sdata),
        .misaligned (misaligned)
    );

    assign cnt_inc = cnt + 1'b1;
    assign to_hit  = (cnt_inc == TO_CNT);

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        adel      = 1'b0;
        ades      = 1'b0;
        accept    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if ((mem_rd || mem_wr) && !flush) begin
                    adel = misaligned && !mem_wr;
                    ades = misaligned && mem_wr;
                    if (!misaligned) begin
                        accept    = 1'b1;
                        stall     = 1'b1;
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (bus_ready || to_hit) state_nxt = S_RESP;
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            ext_q     <= EXT_NONE;
            err_q     <= 1'b0;
            DM        <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                bus_req   <= 1'b1;
                bus_we    <= mem_wr;
                bus_addr  <= {addr[31:2], 2'b00};
                bus_be    <= be;
                bus_wdata <= sdata;
                ext_q     <= mem_wr ? EXT_NONE : extop_in;
                cnt       <= '0;
                err_q     <= 1'b0;
            end else if (state == S_WAIT) begin
                if (bus_ready) begin
                    bus_req <= 1'b0;
                    if (!bus_we) DM <= bus_rdata;
                end else if (to_hit) begin
                    bus_req <= 1'b0;
                    err_q   <= 1'b1;
                    DM      <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end

    // response fields are only non-neutral during the single RESP cycle
    assign valid_out = (state == S_RESP) && !err_q;
    assign bus_err   = (state == S_RESP) && err_q;
    assign BE        = (state == S_RESP) ? bus_be : 4'b1111;
    assign extop_2   = (state == S_RESP) ? ext_q : EXT_NONE;

endmodule

// File: tb/tb_dm_access_unit.sv
// Randomized self-checking bench for dm_access_unit against a
// transaction-level model of the access timeline.
module tb_dm_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_rd, mem_wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [2:0]  extop_in;
    logic        flush;
    logic        stall, adel, ades;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic [31:0] DM;
    logic [3:0]  BE;
    logic [2:0]  extop_2;
    logic        valid_out, bus_err;

    always #5 clk = ~clk;

    dm_access_unit #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .extop_in  (extop_in),
        .flush     (flush),
        .stall     (stall),
        .adel      (adel),
        .ades      (ades),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .DM        (DM),
        .BE        (BE),
        .extop_2   (extop_2),
        .valid_out (valid_out),
        .bus_err   (bus_err)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic        chk_en = 1'b0;
    logic        e_stall, e_adel, e_ades, e_req, e_we;
    logic [31:0] e_addr, e_wdata, e_dm;
    logic [3:0]  e_be, e_BE;
    logic [2:0]  e_ext;
    logic        e_valid, e_err;
    logic [31:0] m_dm = '0;

    int          cyc = 0;
    int          req_cyc = 0;
    logic        req_mark = 1'b0;
    int          n_valid = 0;
    int          n_err = 0;
    int          n_stall = 0;
    int          cap_lat = 0;
    logic        cap_we;
    logic [31:0] cap_addr, cap_wd, cap_dm;
    logic [3:0]  cap_be, cap_BE;
    logic [2:0]  cap_ext;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            check("stall", 32'(stall), 32'(e_stall));
            check("adel", 32'(adel), 32'(e_adel));
            check("ades", 32'(ades), 32'(e_ades));
            check("bus_req", 32'(bus_req), 32'(e_req));
            check("valid_out", 32'(valid_out), 32'(e_valid));
            check("bus_err", 32'(bus_err), 32'(e_err));
            check("DM", DM, e_dm);
            check("BE", 32'(BE), 32'(e_BE));
            check("extop_2", 32'(extop_2), 32'(e_ext));
            if (e_req) begin
                check("bus_we", 32'(bus_we), 32'(e_we));
                check("bus_addr", bus_addr, e_addr);
                check("bus_be", 32'(bus_be), 32'(e_be));
                check("bus_wdata", bus_wdata, e_wdata);
            end
        end
        if (req_mark) req_cyc = cyc;
        if (bus_req) begin
            cap_we   = bus_we;
            cap_addr = bus_addr;
            cap_be   = bus_be;
            cap_wd   = bus_wdata;
        end
        if (valid_out || bus_err) begin
            cap_dm  = DM;
            cap_BE  = BE;
            cap_ext = extop_2;
        end
        if (valid_out) begin
            n_valid++;
            cap_lat = cyc - req_cyc;
        end
        if (bus_err) n_err++;
        if (stall) n_stall++;
    end

    function automatic int nbytes(logic [1:0] sz);
        if (sz == 2'd1) return 2;
        if (sz == 2'd2) return 1;
        return 4;
    endfunction

    function automatic logic [3:0] m_be(logic [1:0] sz, logic [31:0] a);
        int n = nbytes(sz);
        int off = int'(a[1:0]);
        off = off - (off % n);
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wd(logic [1:0] sz, logic [31:0] wd);
        logic [31:0] r;
        int n = nbytes(sz);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        e_stall = 1'b0;
        e_adel  = 1'b0;
        e_ades  = 1'b0;
        e_req   = 1'b0;
        e_we    = 1'b0;
        e_addr  = '0;
        e_be    = '0;
        e_wdata = '0;
        e_valid = 1'b0;
        e_err   = 1'b0;
        e_BE    = 4'hF;
        e_ext   = 3'd0;
        e_dm    = m_dm;
    endtask

    task automatic idle_cycle();
        step();
        req_mark  = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        flush     = 1'($urandom_range(0, 1));
        bus_ready = 1'b0;
        set_idle();
    endtask

    // lat = WAIT cycle (1-based) on which bus_ready is high; > TO never
    task automatic do_access(input logic rd, input logic wr,
                             input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] wd, input logic [2:0] ext,
                             input int lat, input logic [31:0] rdat,
                             input logic fl);
        int  n;
        int  k;
        logic mis, to;
        n   = nbytes(sz);
        mis = (rd || wr) && ((int'(a[1:0]) % n) != 0);
        step();
        mem_rd    = rd;
        mem_wr    = wr;
        size      = sz;
        addr      = a;
        wdata     = wd;
        extop_in  = ext;
        flush     = fl;
        bus_ready = 1'b0;
        req_mark  = 1'b1;
        set_idle();
        e_adel  = rd && !wr && mis && !fl;
        e_ades  = wr && mis && !fl;
        e_stall = (rd || wr) && !mis && !fl;
        if (!e_stall) return;
        k  = (lat <= TO) ? lat : TO;
        to = (lat > TO);
        for (int w = 1; w <= k; w++) begin
            step();
            req_mark  = 1'b0;
            flush     = 1'($urandom_range(0, 1));
            bus_ready = (w == lat);
            bus_rdata = (w == lat) ? rdat : $urandom;
            set_idle();
            e_stall = 1'b1;
            e_req   = 1'b1;
            e_we    = wr;
            e_addr  = {a[31:2], 2'b00};
            e_be    = m_be(sz, a);
            e_wdata = m_wd(sz, wd);
        end
        step();
        bus_ready = 1'b0;
        flush     = 1'b0;
        if (to) m_dm = '0;
        else if (!wr) m_dm = rdat;
        set_idle();
        e_valid = !to;
        e_err   = to;
        e_BE    = m_be(sz, a);
        e_ext   = wr ? 3'd0 : ext;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0, s0;
        reset_n   = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        size      = 2'd0;
        addr      = '0;
        wdata     = '0;
        extop_in  = 3'd0;
        flush     = 1'b0;
        bus_rdata = '0;
        bus_ready = 1'b0;
        #1;
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_DM", DM, 32'd0);
        check("rst_BE", 32'(BE), 32'hF);
        check("rst_extop_2", 32'(extop_2), 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_err", 32'(bus_err), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        set_idle();
        chk_en = 1'b1;
        idle_cycle();

        // lb at 6, ready on the first WAIT cycle
        do_access(1'b1, 1'b0, 2'b10, 32'h6, 32'h0, 3'b001, 1,
                  32'h8899_AABB, 1'b0);
        idle_cycle();
        check("lb_bus_be", 32'(cap_be), 32'h4);
        check("lb_latency", 32'(cap_lat), 32'd2);
        check("lb_DM", cap_dm, 32'h8899_AABB);
        check("lb_BE", 32'(cap_BE), 32'h4);
        check("lb_extop_2", 32'(cap_ext), 32'd1);

        // sh at 2
        do_access(1'b0, 1'b1, 2'b01, 32'h2, 32'h0000_1234, 3'd0, 2,
                  32'h0, 1'b0);
        idle_cycle();
        check("sh_bus_we", 32'(cap_we), 32'd1);
        check("sh_bus_be", 32'(cap_be), 32'hC);
        check("sh_bus_wdata", cap_wd, 32'h1234_1234);
        check("sh_bus_addr", cap_addr, 32'h0);
        check("sh_DM_held", DM, 32'h8899_AABB);

        // misaligned lw at 5
        do_access(1'b1, 1'b0, 2'b00, 32'h5, 32'h0, 3'd0, 1,
                  32'h0, 1'b0);
        #1;
        check("lw_mis_adel", 32'(adel), 32'd1);
        check("lw_mis_stall", 32'(stall), 32'd0);
        idle_cycle();
        #1;
        check("lw_mis_no_req", 32'(bus_req), 32'd0);

        // timeout with bus_ready never high
        e0 = n_err;
        v0 = n_valid;
        do_access(1'b1, 1'b0, 2'b00, 32'h20, 32'h0, 3'd0, 99,
                  32'h0, 1'b0);
        idle_cycle();
        check("to_err_pulses", 32'(n_err - e0), 32'd1);
        check("to_no_valid", 32'(n_valid - v0), 32'd0);
        check("to_DM", DM, 32'd0);
        do_access(1'b1, 1'b0, 2'b00, 32'h24, 32'h0, 3'd0, 1,
                  32'hCAFE_F00D, 1'b0);
        idle_cycle();
        check("to_recover_DM", DM, 32'hCAFE_F00D);

        // reset during the second WAIT cycle
        v0 = n_valid;
        step();
        mem_rd    = 1'b1;
        mem_wr    = 1'b0;
        size      = 2'b00;
        addr      = 32'h40;
        flush     = 1'b0;
        req_mark  = 1'b1;
        set_idle();
        e_stall = 1'b1;
        step();
        req_mark = 1'b0;
        set_idle();
        e_stall = 1'b1;
        e_req   = 1'b1;
        e_we    = 1'b0;
        e_addr  = 32'h40;
        e_be    = 4'hF;
        e_wdata = wdata;
        step();
        chk_en  = 1'b0;
        mem_rd  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_wait_bus_req", 32'(bus_req), 32'd0);
        check("rst_wait_stall", 32'(stall), 32'd0);
        check("rst_wait_DM", DM, 32'd0);
        step();
        reset_n = 1'b1;
        m_dm    = '0;
        set_idle();
        chk_en = 1'b1;
        for (int i = 0; i < 4; i++) idle_cycle();
        check("rst_wait_no_valid", 32'(n_valid - v0), 32'd0);
        v0 = n_valid;
        do_access(1'b0, 1'b1, 2'b00, 32'h44, 32'hDEAD_BEEF, 3'd0, 2,
                  32'h0, 1'b0);
        idle_cycle();
        check("rst_sw_valid", 32'(n_valid - v0), 32'd1);
        check("rst_sw_wdata", cap_wd, 32'hDEAD_BEEF);

        // back-to-back lw then sw, 3 wait cycles each
        v0 = n_valid;
        s0 = n_stall;
        do_access(1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 3'd0, 3,
                  32'h0102_0304, 1'b0);
        do_access(1'b0, 1'b1, 2'b00, 32'h14, 32'h5555_AAAA, 3'd0, 3,
                  32'h0, 1'b0);
        idle_cycle();
        check("b2b_valid", 32'(n_valid - v0), 32'd2);
        check("b2b_stall_cycles", 32'(n_stall - s0), 32'd8);

        for (int i = 0; i < 300; i++) begin
            do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), $urandom, $urandom,
                      3'($urandom_range(0, 4)),
                      int'($urandom_range(1, TO + 2)), $urandom,
                      ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        idle_cycle();
        idle_cycle();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
